// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: UART serial transmit engine.
// Takes bytes over a ready/valid handshake and sends each one as
// start, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds the parity bit and the
// io_parity_odd port.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | line high, ready when io_en is set
// START  | start bit (0) for one bit period
// DATA   | data bit bit_idx for one bit period
// PARITY | parity bit for one bit period (macro builds only)
// STOP   | stop level (1) for one or two bit periods
//
// io_out is registered from the next-state decode, so it changes on the
// same edge as the state register. A back-to-back accept can only happen
// from IDLE, which stretches the stop level by one cycle between frames.

module uart_tx_shifter #(
   parameter int DIV_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_en,
   input  logic [DIV_W-1:0] io_div,
   input  logic             io_nstop,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [7:0]       io_in_bits,
   output logic             io_out,
`ifdef UART_TX_PARITY_EN
   input  logic             io_parity_odd,
`endif
   output logic             io_busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic [2:0]       state, state_nxt;
   logic [DIV_W-1:0] presc, presc_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic             stop_second, stop_second_nxt;
   logic [7:0]       data_q;
   logic [DIV_W-1:0] div_q;
   logic             nstop_q;
   logic             par_odd_q;
   logic             out_nxt;
   logic             accept;
   logic             tick;

   assign io_in_ready = (state == ST_IDLE) & io_en & ~reset;
   assign io_busy     = (state != ST_IDLE);
   assign accept      = io_in_valid & io_in_ready;
   assign tick        = (presc == div_q);

   // Next-state, prescaler, bit index and line level decode
   always_comb begin
      state_nxt       = state;
      presc_nxt       = presc;
      bit_idx_nxt     = bit_idx;
      stop_second_nxt = stop_second;
      if (state != ST_IDLE) begin
         if (tick) presc_nxt = '0;
         else      presc_nxt = presc + DIV_W'(1);
      end
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt       = ST_START;
               presc_nxt       = '0;
               bit_idx_nxt     = 3'd0;
               stop_second_nxt = 1'b0;
            end
         end
         ST_START: begin
            if (tick) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (tick) begin
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (nstop_q && !stop_second) begin
                  stop_second_nxt = 1'b1;
               end else begin
                  stop_second_nxt = 1'b0;
                  state_nxt       = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            presc_nxt = '0;
         end
      endcase

      out_nxt = 1'b1;
      case (state_nxt)
         ST_START:  out_nxt = 1'b0;
         ST_DATA:   out_nxt = data_q[bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: out_nxt = (^data_q) ^ par_odd_q;
`endif
         default:   out_nxt = 1'b1;
      endcase
   end

   // Frame state and registered line output
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         presc       <= '0;
         bit_idx     <= 3'd0;
         stop_second <= 1'b0;
         io_out      <= 1'b1;
      end else begin
         state       <= state_nxt;
         presc       <= presc_nxt;
         bit_idx     <= bit_idx_nxt;
         stop_second <= stop_second_nxt;
         io_out      <= out_nxt;
      end
   end

   // Per-frame configuration captured at accept so mid-frame changes are ignored
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q    <= 8'h00;
         div_q     <= '0;
         nstop_q   <= 1'b0;
         par_odd_q <= 1'b0;
      end else if (accept) begin
         data_q  <= io_in_bits;
         div_q   <= io_div;
         nstop_q <= io_nstop;
`ifdef UART_TX_PARITY_EN
         par_odd_q <= io_parity_odd;
`else
         par_odd_q <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_shifter.sv
// tb_uart_tx_shifter: randomized and directed bench for uart_tx_shifter.
// Expected line levels come from a per-frame bit list (start, data LSB-first,
// optional parity, stop bits), each level held div+1 cycles.

module tb_uart_tx_shifter;

`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        io_en = 1'b0;
   logic [15:0] io_div = 16'd0;
   logic        io_nstop = 1'b0;
   logic        io_in_valid = 1'b0;
   logic [7:0]  io_in_bits = 8'h00;
   logic        io_in_ready;
   logic        io_out;
   logic        io_busy;
   logic        io_parity_odd = 1'b0;

   int errors = 0;
   int checks = 0;

   uart_tx_shifter #(.DIV_W(16)) dut (
      .clock         (clock),
      .reset         (reset),
      .io_en         (io_en),
      .io_div        (io_div),
      .io_nstop      (io_nstop),
      .io_in_valid   (io_in_valid),
      .io_in_ready   (io_in_ready),
      .io_in_bits    (io_in_bits),
      .io_out        (io_out),
`ifdef UART_TX_PARITY_EN
      .io_parity_odd (io_parity_odd),
`endif
      .io_busy       (io_busy)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Caller is at a negedge with the DUT idle and io_en high.
   // Line/busy/ready are checked every cycle of the frame and on the idle cycle after it.
   task automatic send_frame(input logic [7:0] b, input int div, input bit nstop,
                             input bit odd, input bit keep_valid, input bit drop_en,
                             input bit scramble);
      bit fb[$];
      int d;
      int len;
      fb.push_back(1'b0);
      for (int k = 0; k < 8; k++) fb.push_back(b[k]);
      if (PBITS == 1) fb.push_back((^b) ^ odd);
      fb.push_back(1'b1);
      if (nstop) fb.push_back(1'b1);
      d   = div + 1;
      len = fb.size() * d;

      io_div        = 16'(div);
      io_nstop      = nstop;
      io_parity_odd = odd;
      io_in_bits    = b;
      io_in_valid   = 1'b1;
      #1 check_val("ready_before_accept", 32'(io_in_ready), 32'd1);

      for (int i = 0; i < len; i++) begin
         @(negedge clock);
         if (i == 0 && !keep_valid) io_in_valid = 1'b0;
         if (i == len / 2) begin
            if (scramble) begin
               io_div        = 16'($urandom_range(0, 7));
               io_nstop      = 1'($urandom_range(0, 1));
               io_parity_odd = 1'($urandom_range(0, 1));
               io_in_bits    = 8'($urandom);
            end
            if (drop_en) io_en = 1'b0;
         end
         #1 check_val("frame_out_busy_ready", 32'({io_out, io_busy, io_in_ready}),
                      32'({fb[i / d], 1'b1, 1'b0}));
      end
      @(negedge clock);
      #1 check_val("idle_after_frame", 32'({io_out, io_busy, io_in_ready}),
                   32'({1'b1, 1'b0, io_en}));
   endtask

   task automatic idle_cycles(input int n, input bit exp_ready);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         #1 check_val("idle_hold", 32'({io_out, io_busy, io_in_ready}),
                      32'({1'b1, 1'b0, exp_ready}));
      end
   endtask

   initial begin
      io_en = 1'b1;
      repeat (3) @(negedge clock);
      check_val("reset_state", 32'({io_out, io_busy, io_in_ready}), 32'({1'b1, 1'b0, 1'b0}));
      reset = 1'b0;
      #1 check_val("ready_after_reset", 32'(io_in_ready), 32'd1);

      // directed frames
      send_frame(8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA3, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (PBITS == 1) begin
         send_frame(8'h07, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         send_frame(8'h07, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // back-to-back at div=0: stop level stretched by the idle cycle
      send_frame(8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // enable low blocks acceptance
      io_en       = 1'b0;
      io_in_valid = 1'b1;
      idle_cycles(5, 1'b0);
      io_in_valid = 1'b0;
      io_en       = 1'b1;
      #1;

      // enable dropped mid-frame: frame completes, no further accept
      send_frame(8'h96, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      idle_cycles(4, 1'b0);
      io_in_valid = 1'b0;
      io_en       = 1'b1;
      #1;

      // reset during data bit 3 (div=2)
      io_div      = 16'd2;
      io_nstop    = 1'b0;
      io_in_bits  = 8'h3C;
      io_in_valid = 1'b1;
      @(negedge clock);
      io_in_valid = 1'b0;
      repeat (4 * 3 + 1) @(negedge clock);
      #1 check_val("in_data_before_reset", 32'({io_out, io_busy}), 32'({1'b1, 1'b1}));
      reset = 1'b1;
      @(negedge clock);
      #1 check_val("after_mid_reset", 32'({io_out, io_busy, io_in_ready}),
                   32'({1'b1, 1'b0, 1'b0}));
      reset = 1'b0;
      #1 check_val("ready_after_mid_reset", 32'(io_in_ready), 32'd1);
      send_frame(8'hC5, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // randomized frames with mid-frame config scrambling
      for (int n = 0; n < 16; n++) begin
         send_frame(8'($urandom), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            io_in_valid = 1'b0;
            idle_cycles($urandom_range(1, 3), 1'b1);
         end
      end
      io_in_valid = 1'b0;
      idle_cycles(2, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
